// File: rtl/cp0_exception_ctrl_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, Status/Cause
// bit positions and small helpers used by the exception sequencer.
package cp0_exception_ctrl_pkg;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 10;
    localparam int STATUS_IM_HI = 15;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;

    function automatic logic int_request(input logic [31:0] status, input logic [5:0] pending);
        return status[STATUS_IE] & ~status[STATUS_EXL]
             & (|(pending & status[STATUS_IM_HI:STATUS_IM_LO]));
    endfunction

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

    function automatic logic [31:0] cause_with_exc(input logic [31:0] cause, input logic bd,
                                                   input logic [4:0] code);
        logic [31:0] c;
        c = cause;
        c[CAUSE_BD] = bd;
        c[CAUSE_EXC_HI:CAUSE_EXC_LO] = code;
        return c;
    endfunction

endpackage

// File: rtl/cp0_exception_ctrl_priority_enc.sv
// Fixed-priority selection of one pending event; ERET only wins when no
// exception or qualified interrupt is present.
module exc_priority_enc
    import cp0_exception_ctrl_pkg::*;
(
    input  logic       int_req,
    input  logic       adel,
    input  logic       ri,
    input  logic       ov,
    input  logic       syscall,
    input  logic       brk,
    input  logic       ades,
    input  logic       eret,
    output logic       valid,
    output logic       is_eret,
    output logic [4:0] code
);

    // Priority chain, highest first
    always_comb begin
        valid   = 1'b1;
        is_eret = 1'b0;
        code    = EXC_INT;
        if (int_req) begin
            code = EXC_INT;
        end else if (adel) begin
            code = EXC_ADEL;
        end else if (ri) begin
            code = EXC_RI;
        end else if (ov) begin
            code = EXC_OV;
        end else if (syscall) begin
            code = EXC_SYS;
        end else if (brk) begin
            code = EXC_BP;
        end else if (ades) begin
            code = EXC_ADES;
        end else if (eret) begin
            is_eret = 1'b1;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_exception_ctrl.sv
// Exception entry / ERET exit sequencer: serialises CP0 updates through the
// single write port while stalling, then flushes and redirects fetch.
module cp0_exception_ctrl
    import cp0_exception_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        int_pending_i,
    input  logic              adel_i,
    input  logic              ri_i,
    input  logic              ov_i,
    input  logic              syscall_i,
    input  logic              break_i,
    input  logic              ades_i,
    input  logic              eret_i,
    input  logic [31:0]       pc_i,
    input  logic              in_delay_slot_i,
    input  logic [31:0]       bad_vaddr_i,
    input  logic [31:0]       status_i,
    input  logic [31:0]       cause_i,
    input  logic [31:0]       epc_i,
    output logic              cp0_we_o,
    output logic [ADDR_W-1:0] cp0_waddr_o,
    output logic [31:0]       cp0_wdata_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_BADV   = 3'd1,
        S_W_EPC    = 3'd2,
        S_W_CAUSE  = 3'd3,
        S_W_STATUS = 3'd4,
        S_E_STATUS = 3'd5,
        S_REDIRECT = 3'd6
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        evt_valid_s, evt_eret_s, detect_s;
    logic [4:0]  evt_code_s, code_r;
    logic [31:0] pc_r, badv_r, status_r, cause_r, epc_r;
    logic        bd_r, is_eret_r;

    exc_priority_enc u_prio (
        .int_req (int_request(status_i, int_pending_i)),
        .adel    (adel_i),
        .ri      (ri_i),
        .ov      (ov_i),
        .syscall (syscall_i),
        .brk     (break_i),
        .ades    (ades_i),
        .eret    (eret_i),
        .valid   (evt_valid_s),
        .is_eret (evt_eret_s),
        .code    (evt_code_s)
    );

    assign detect_s = (state_r == S_IDLE) & evt_valid_s & ~rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: address faults log BadVAddr first; a nested entry keeps EPC
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!evt_valid_s) begin
                    state_nxt_s = S_IDLE;
                end else if (evt_eret_s) begin
                    state_nxt_s = S_E_STATUS;
                end else if (is_addr_exc(evt_code_s)) begin
                    state_nxt_s = S_W_BADV;
                end else if (status_i[STATUS_EXL]) begin
                    state_nxt_s = S_W_CAUSE;
                end else begin
                    state_nxt_s = S_W_EPC;
                end
            end
            S_W_BADV:   state_nxt_s = status_r[STATUS_EXL] ? S_W_CAUSE : S_W_EPC;
            S_W_EPC:    state_nxt_s = S_W_CAUSE;
            S_W_CAUSE:  state_nxt_s = S_W_STATUS;
            S_W_STATUS: state_nxt_s = S_REDIRECT;
            S_E_STATUS: state_nxt_s = S_REDIRECT;
            S_REDIRECT: state_nxt_s = S_IDLE;
            default:    state_nxt_s = S_IDLE;
        endcase
    end

    // Event capture on the detect cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            code_r    <= 5'd0;
            pc_r      <= 32'd0;
            bd_r      <= 1'b0;
            badv_r    <= 32'd0;
            status_r  <= 32'd0;
            cause_r   <= 32'd0;
            epc_r     <= 32'd0;
            is_eret_r <= 1'b0;
        end else if (detect_s) begin
            code_r    <= evt_code_s;
            pc_r      <= pc_i;
            bd_r      <= in_delay_slot_i;
            badv_r    <= bad_vaddr_i;
            status_r  <= status_i;
            cause_r   <= cause_i;
            epc_r     <= epc_i;
            is_eret_r <= evt_eret_s;
        end
    end

    // Output decode from the registered state; reset forces everything quiet
    always_comb begin
        cp0_we_o    = 1'b0;
        cp0_waddr_o = '0;
        cp0_wdata_o = 32'd0;
        stall_o     = 1'b0;
        flush_o     = 1'b0;
        new_pc_o    = 32'd0;
        busy_o      = 1'b0;
        if (!rst) begin
            busy_o  = (state_r != S_IDLE);
            stall_o = 1'b1;
            case (state_r)
                S_IDLE: stall_o = detect_s;
                S_W_BADV: begin
                    cp0_we_o    = 1'b1;
                    cp0_waddr_o = ADDR_W'(CP0_REG_BADVADDR);
                    cp0_wdata_o = badv_r;
                end
                S_W_EPC: begin
                    cp0_we_o    = 1'b1;
                    cp0_waddr_o = ADDR_W'(CP0_REG_EPC);
                    cp0_wdata_o = bd_r ? (pc_r - 32'd4) : pc_r;
                end
                S_W_CAUSE: begin
                    cp0_we_o    = 1'b1;
                    cp0_waddr_o = ADDR_W'(CP0_REG_CAUSE);
                    cp0_wdata_o = cause_with_exc(cause_r, bd_r, code_r);
                end
                S_W_STATUS: begin
                    cp0_we_o    = 1'b1;
                    cp0_waddr_o = ADDR_W'(CP0_REG_STATUS);
                    cp0_wdata_o = status_r | 32'h0000_0002;
                end
                S_E_STATUS: begin
                    cp0_we_o    = 1'b1;
                    cp0_waddr_o = ADDR_W'(CP0_REG_STATUS);
                    cp0_wdata_o = status_r & ~32'h0000_0002;
                end
                S_REDIRECT: begin
                    flush_o  = 1'b1;
                    new_pc_o = is_eret_r ? epc_r : EXC_VECTOR;
                end
                default: stall_o = 1'b0;
            endcase
        end else begin
            stall_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Self-checking bench: transaction-level model builds the expected per-cycle
// output script for each event; directed cases pin literal values.
module tb_cp0_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_pending_i;
    logic        adel_i, ri_i, ov_i, syscall_i, break_i, ades_i, eret_i;
    logic [31:0] pc_i, bad_vaddr_i, status_i, cause_i, epc_i;
    logic        in_delay_slot_i;
    logic        cp0_we_o, stall_o, flush_o, busy_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_wdata_o, new_pc_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        flush;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];

    cp0_exception_ctrl dut (
        .clk(clk), .rst(rst), .int_pending_i(int_pending_i),
        .adel_i(adel_i), .ri_i(ri_i), .ov_i(ov_i), .syscall_i(syscall_i),
        .break_i(break_i), .ades_i(ades_i), .eret_i(eret_i),
        .pc_i(pc_i), .in_delay_slot_i(in_delay_slot_i), .bad_vaddr_i(bad_vaddr_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
        .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t mk(input logic we, input logic [4:0] a, input logic [31:0] d,
                                input logic fl, input logic [31:0] np);
        exp_t e;
        e.we = we; e.addr = a; e.data = d; e.flush = fl; e.npc = np;
        return e;
    endfunction

    // Model: pick the winning event from the architectural priority list
    function automatic void model_event(output bit v, output bit er, output int code);
        bit ireq;
        bit fl[7];
        int cd[7];
        ireq = status_i[0] && !status_i[1] && ((int_pending_i & status_i[15:10]) != 6'd0);
        fl = '{ireq, adel_i, ri_i, ov_i, syscall_i, break_i, ades_i};
        cd = '{0, 4, 10, 12, 8, 9, 5};
        v = 1'b0; er = 1'b0; code = 0;
        for (int i = 0; i < 7; i++) begin
            if (fl[i] && !v) begin
                v = 1'b1; code = cd[i];
            end
        end
        if (!v && eret_i) begin
            v = 1'b1; er = 1'b1;
        end
    endfunction

    // Compare every cycle against the model's expected script
    always @(negedge clk) begin
        exp_t e;
        bit   st, bz, v, er;
        int   code;
        logic [31:0] cz;
        e = mk(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        st = 1'b0; bz = 1'b0;
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            st = 1'b1; bz = 1'b1;
        end else begin
            model_event(v, er, code);
            if (v) begin
                st = 1'b1;
                if (er) begin
                    exp_q.push_back(mk(1'b1, 5'd12, status_i & ~32'd2, 1'b0, 32'd0));
                    exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, epc_i));
                end else begin
                    if (code == 4 || code == 5)
                        exp_q.push_back(mk(1'b1, 5'd8, bad_vaddr_i, 1'b0, 32'd0));
                    if (!status_i[1])
                        exp_q.push_back(mk(1'b1, 5'd14, in_delay_slot_i ? pc_i - 32'd4 : pc_i,
                                           1'b0, 32'd0));
                    cz = {in_delay_slot_i, cause_i[30:7], code[4:0], cause_i[1:0]};
                    exp_q.push_back(mk(1'b1, 5'd13, cz, 1'b0, 32'd0));
                    exp_q.push_back(mk(1'b1, 5'd12, status_i | 32'd2, 1'b0, 32'd0));
                    exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 32'hBFC00380));
                end
            end
        end
        chk("m_we", cp0_we_o, e.we);
        chk("m_waddr", cp0_waddr_o, e.addr);
        chk("m_wdata", cp0_wdata_o, e.data);
        chk("m_stall", stall_o, st);
        chk("m_flush", flush_o, e.flush);
        chk("m_new_pc", new_pc_o, e.npc);
        chk("m_busy", busy_o, bz);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        adel_i = 1'b0; ri_i = 1'b0; ov_i = 1'b0; syscall_i = 1'b0;
        break_i = 1'b0; ades_i = 1'b0; eret_i = 1'b0; int_pending_i = 6'd0;
    endtask

    task automatic expect_write(input string name, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        chk({name, "_we"}, cp0_we_o, 32'd1);
        chk({name, "_addr"}, cp0_waddr_o, a);
        chk({name, "_data"}, cp0_wdata_o, d);
        chk({name, "_stall"}, stall_o, 32'd1);
        next_cycle();
    endtask

    task automatic expect_flush(input string name, input logic [31:0] np);
        @(negedge clk);
        chk({name, "_flush"}, flush_o, 32'd1);
        chk({name, "_new_pc"}, new_pc_o, np);
        chk({name, "_we"}, cp0_we_o, 32'd0);
        next_cycle();
        @(negedge clk);
        chk({name, "_idle"}, busy_o, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        clear_flags();
        syscall_i = 1'b1;
        pc_i = 32'd0; in_delay_slot_i = 1'b0; bad_vaddr_i = 32'd0;
        status_i = 32'd0; cause_i = 32'd0; epc_i = 32'd0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_we", cp0_we_o, 32'd0);
            chk("rst_stall", stall_o, 32'd0);
        end
        next_cycle();
        rst = 1'b0; syscall_i = 1'b0;

        // Syscall
        next_cycle();
        syscall_i = 1'b1; pc_i = 32'h80001000; status_i = 32'h10000001;
        @(negedge clk);
        chk("sys_T_stall", stall_o, 32'd1);
        next_cycle();
        clear_flags();
        expect_write("sys_epc", 5'd14, 32'h80001000);
        expect_write("sys_cause", 5'd13, 32'h00000020);
        expect_write("sys_status", 5'd12, 32'h10000003);
        expect_flush("sys", 32'hBFC00380);

        // AdEL in a delay slot
        next_cycle();
        adel_i = 1'b1; pc_i = 32'h80000004; in_delay_slot_i = 1'b1;
        bad_vaddr_i = 32'h00000003; status_i = 32'h00000000;
        next_cycle();
        clear_flags();
        expect_write("adel_badv", 5'd8, 32'h00000003);
        expect_write("adel_epc", 5'd14, 32'h80000000);
        expect_write("adel_cause", 5'd13, 32'h80000010);
        expect_write("adel_status", 5'd12, 32'h00000002);
        expect_flush("adel", 32'hBFC00380);

        // Masked interrupt, then unmasked together with overflow
        next_cycle();
        in_delay_slot_i = 1'b0; int_pending_i = 6'b000001; status_i = 32'h00000001;
        @(negedge clk);
        chk("int_masked_stall", stall_o, 32'd0);
        next_cycle();
        status_i = 32'h00000401; ov_i = 1'b1; cause_i = 32'h00000400; pc_i = 32'h80000100;
        next_cycle();
        clear_flags();
        expect_write("int_epc", 5'd14, 32'h80000100);
        expect_write("int_cause", 5'd13, 32'h00000400);
        expect_write("int_status", 5'd12, 32'h00000403);
        expect_flush("int", 32'hBFC00380);

        // Nested RI: EPC untouched
        next_cycle();
        ri_i = 1'b1; status_i = 32'h00000003; cause_i = 32'd0;
        next_cycle();
        clear_flags();
        expect_write("nest_cause", 5'd13, 32'h00000028);
        expect_write("nest_status", 5'd12, 32'h00000003);
        expect_flush("nest", 32'hBFC00380);

        // ERET
        next_cycle();
        eret_i = 1'b1; epc_i = 32'h80002000; status_i = 32'h10000003;
        next_cycle();
        clear_flags();
        expect_write("eret_status", 5'd12, 32'h10000001);
        expect_flush("eret", 32'h80002000);

        // ERET aborted by reset at T+1
        next_cycle();
        eret_i = 1'b1;
        next_cycle();
        clear_flags();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we", cp0_we_o, 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_flush", flush_o, 32'd0);
        chk("abort_busy", busy_o, 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rst = ($urandom_range(0, 199) == 0);
            adel_i = ($urandom_range(0, 9) == 0);
            ri_i = ($urandom_range(0, 9) == 0);
            ov_i = ($urandom_range(0, 9) == 0);
            syscall_i = ($urandom_range(0, 9) == 0);
            break_i = ($urandom_range(0, 9) == 0);
            ades_i = ($urandom_range(0, 9) == 0);
            eret_i = ($urandom_range(0, 5) == 0);
            int_pending_i = 6'($urandom);
            status_i = $urandom;
            cause_i = $urandom;
            epc_i = $urandom;
            pc_i = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            bad_vaddr_i = $urandom;
            in_delay_slot_i = 1'($urandom);
        end
        next_cycle();
        rst = 1'b0;
        clear_flags();
        repeat (8) next_cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cp0_exception_ctrl.md
Name: cp0_exception_ctrl

Overview:
- Sequences all exception entry and ERET exit through CP0's single write port.
- Sits beside CP0 at the MEM/WB boundary.
- Takes exception flags from the MEM stage and the CP0 Status/Cause/EPC register values.
- Prioritises one event, then issues an ordered series of CP0 register writes while stalling the pipeline.
- Finishes with a one-cycle flush and a redirect PC for the fetch stage.

Parameters:
- EXC_VECTOR, 32'hBFC00380, exception handler entry PC.
- ADDR_W, 5, CP0 register address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset (RST_ENABLE = 1)
- int_pending_i  in  6  hardware interrupt lines, same as CP0 Cause[15:10]
- adel_i, ri_i, ov_i, syscall_i, break_i, ades_i, eret_i  in  1 each  MEM-stage exception and ERET flags
- pc_i  in  32  MEM-stage instruction PC
- in_delay_slot_i  in  1  MEM instruction is in a branch delay slot
- bad_vaddr_i  in  32  faulting address for AdEL/AdES
- status_i, cause_i, epc_i  in  32 each  current CP0 values
- cp0_we_o  out  1  CP0 write enable
- cp0_waddr_o  out  5  CP0 write address
- cp0_wdata_o  out  32  CP0 write data
- stall_o  out  1  freeze IF..MEM
- flush_o  out  1  kill all in-flight instructions
- new_pc_o  out  32  redirect target, valid when flush_o = 1
- busy_o  out  1  FSM is not in IDLE

Behaviour:
- Reset (synchronous, rst = 1): state = IDLE; all outputs 0; capture registers 0. Reset mid-sequence aborts with no further CP0 writes.
- Interrupt qualify: int_req = Status.IE[0] & ~Status.EXL[1] & |(int_pending_i & Status.IM[15:10]).
- Priority, highest first, with ExcCode:
  - Int 0
  - AdEL 4
  - RI 10
  - Ov 12
  - Sys 8
  - Bp 9
  - AdES 5
  - ERET (no code)
- Inputs are sampled only in IDLE. Flags arriving while busy are ignored; the flush discards them.
- Detect cycle T (IDLE, any event):
  - stall_o = 1 combinationally.
  - Capture: code, pc_i, in_delay_slot_i, bad_vaddr_i, status_i, cause_i, epc_i.
  - Next state per sequence below.
- Exception sequence: [W_BADV] -> [W_EPC] -> W_CAUSE -> W_STATUS -> REDIRECT -> IDLE.
  - W_BADV only for AdEL/AdES.
  - W_EPC is skipped if the captured Status.EXL = 1; EPC is not overwritten.
- ERET sequence: E_STATUS -> REDIRECT -> IDLE.
- State writes (cp0_we_o = 1 for exactly one cycle per write state, outputs decoded from the registered state):
  - W_BADV: addr 8, data bad_vaddr.
  - W_EPC: addr 14, data in_delay_slot ? pc-4 : pc (32-bit modular subtraction, wrap allowed).
  - W_CAUSE: addr 13, data = captured cause with [31] = BD and [6:2] = code. CP0 accepts BD and ExcCode on this port.
  - W_STATUS: addr 12, data = captured status with [1] = 1.
  - E_STATUS: addr 12, data = captured status with [1] = 0.
- REDIRECT: flush_o = 1 and stall_o = 1 for one cycle.
  - new_pc_o = EXC_VECTOR for exceptions, captured epc for ERET.
  - cp0_we_o = 0.
  - new_pc_o = 0 outside REDIRECT.
- stall_o = 1 in every non-IDLE state; busy_o = (state != IDLE).
- Latency:
  - Plain exception: writes at T+1..T+3, flush at T+4.
  - Address exception: writes at T+1..T+4, flush at T+5.
  - Nested exception (EXL = 1): one write fewer.
  - ERET: write at T+1, flush at T+2.
- Simultaneous events: only the highest priority is taken. ERET together with any exception takes the exception.
- No event in IDLE: all outputs 0.

Decomposition:
- Shared package/header `cp0.vh`: CP0_REG_* addresses (BadVAddr 8, Status 12, Cause 13, EPC 14), EXC_* codes, Status/Cause bit positions (IE 0, EXL 1, IM 15:10, BD 31, EXC 6:2).
- FSM state encodings stay local to the module.
- One sub-module: exc_priority_enc. Purely combinational; flags + int_req -> {valid, is_eret, code[4:0]}.

Test Plan:
- Reset: rst = 1 for 3 cycles while syscall_i = 1 -> all outputs 0, no writes.
- Syscall: pc_i = 0x80001000, delay slot 0, status_i = 0x10000001.
  - Required: T+1 EPC <- 0x80001000; T+2 Cause code 8, BD 0; T+3 Status <- 0x10000003; T+4 flush, new_pc 0xBFC00380.
  - stall_o high T..T+4.
- AdEL in delay slot: pc_i = 0x80000004, bad_vaddr_i = 0x00000003.
  - Required: BadVAddr <- 3, EPC <- 0x80000000, Cause <- 0x80000010; flush at T+5.
- Interrupt with masking: int_pending_i = 6'b000001 with IM bit 10 = 0 -> no action. With IM bit 10 = 1, IE = 1 -> code 0 sequence.
  - Priority: same cycle as ov_i = 1 -> Int wins.
- Nested: status_i EXL = 1 plus ri_i -> no EPC write; Cause code 10 at T+1, Status at T+2, flush at T+3.
- ERET: epc_i = 0x80002000, status_i = 0x10000003.
  - Required: T+1 Status <- 0x10000001; T+2 flush, new_pc 0x80002000.
  - Assert rst at T+1 -> no flush; IDLE next cycle.
